apb_master_fsm: RTL and testbench

//  APB initiator: the requester end of the Penable/Pwrite/Paddr/Pwdata/Prdata/Pselx bus, complementing the slave-side driver.

---
 rtl/apb_master_fsm.sv | 117 +++++++++++
 tb/tb_apb_master_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// APB initiator: accepts single read/write commands on a valid/ready port and runs
// the two-cycle SETUP/ACCESS sequence toward one of four address-decoded slaves.
module apb_master_fsm #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          SLV_SIZE_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Pwrite,
    output logic [3:0]  Pselx,
    output logic        Penable,
    input  logic [31:0] Prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    localparam int TAG_LSB = SLV_SIZE_LOG2 + 2;

    state_t      state, state_nxt;
    logic [31:0] paddr_nxt, pwdata_nxt, rsp_rdata_nxt;
    logic        pwrite_nxt, penable_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [3:0]  pselx_nxt;
    logic        hit, accept;
    logic [1:0]  idx;

    assign hit       = (cmd_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign idx       = cmd_addr[SLV_SIZE_LOG2 +: 2];
    assign cmd_ready = !rst && (state == IDLE || state == ACCESS);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt     = state;
        paddr_nxt     = Paddr;
        pwdata_nxt    = Pwdata;
        pwrite_nxt    = Pwrite;
        pselx_nxt     = Pselx;
        penable_nxt   = Penable;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = rsp_err;
        rsp_rdata_nxt = rsp_rdata;

        case (state)
            IDLE: ;
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                state_nxt     = IDLE;
                pselx_nxt     = 4'b0000;
                penable_nxt   = 1'b0;
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b0;
                rsp_rdata_nxt = Pwrite ? 32'h0 : Prdata;
            end
            ERR: begin
                state_nxt     = IDLE;
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b1;
                rsp_rdata_nxt = 32'h0;
            end
            default: state_nxt = IDLE;
        endcase

        // A new command can only be accepted in IDLE or ACCESS; in ACCESS it overrides the return to IDLE.
        if (accept) begin
            penable_nxt = 1'b0;
            if (hit) begin
                state_nxt  = SETUP;
                paddr_nxt  = cmd_addr;
                pwdata_nxt = cmd_wdata;
                pwrite_nxt = cmd_write;
                pselx_nxt  = 4'b0001 << idx;
            end else begin
                state_nxt = ERR;
                pselx_nxt = 4'b0000;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            Paddr     <= 32'h0;
            Pwdata    <= 32'h0;
            Pwrite    <= 1'b0;
            Pselx     <= 4'b0000;
            Penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            state     <= state_nxt;
            Paddr     <= paddr_nxt;
            Pwdata    <= pwdata_nxt;
            Pwrite    <= pwrite_nxt;
            Pselx     <= pselx_nxt;
            Penable   <= penable_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Self-checking bench for apb_master_fsm: directed scenarios followed by random traffic,
// compared cycle by cycle against a transaction-level schedule model.
module tb_apb_master_fsm;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          SZ   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0, cmd_wdata = 32'h0, Prdata = 32'h0;
    logic        cmd_ready, rsp_valid, rsp_err, Pwrite, Penable;
    logic [31:0] rsp_rdata, Paddr, Pwdata;
    logic [3:0]  Pselx;

    apb_master_fsm #(.BASE_ADDR(BASE), .SLV_SIZE_LOG2(SZ)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx),
        .Penable(Penable), .Prdata(Prdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // One accepted command; k is the cycle in which it was accepted.
    typedef struct {
        int          k;
        bit          write;
        bit          hit;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        q[$];
    int          cyc = 0;
    int          free_at = 0;
    bit          rst_prev = 1'b1;
    logic [31:0] m_paddr = 32'h0, m_pwdata = 32'h0;
    bit          m_pwrite = 1'b0;

    // One clock cycle: drive inputs, check outputs against the schedule, then record any acceptance.
    task automatic step(input bit r, input bit v, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] prd);
        logic [3:0]  e_sel;
        bit          e_en, e_rv, e_err, e_rdy, a_hit;
        logic [31:0] e_rd;
        int          lat;
        txn_t        t;
        @(negedge clk);
        rst = r; cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d; Prdata = prd;
        #1;
        e_sel = 4'b0; e_en = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rd = 32'h0;
        if (rst_prev) begin
            q.delete();
            m_paddr = 32'h0; m_pwdata = 32'h0; m_pwrite = 1'b0;
            free_at = cyc;
            check("rst_err", {31'b0, rsp_err}, 32'h0);
            check("rst_rdata", rsp_rdata, 32'h0);
        end else begin
            foreach (q[i]) begin
                if (q[i].hit && (cyc == q[i].k + 1 || cyc == q[i].k + 2)) begin
                    e_sel    = 4'(1 << ((q[i].addr >> SZ) & 3));
                    m_paddr  = q[i].addr;
                    m_pwdata = q[i].wdata;
                    m_pwrite = q[i].write;
                    if (cyc == q[i].k + 2) begin
                        e_en = 1'b1;
                        if (!q[i].write) q[i].rdata = prd;
                    end
                end
                lat = q[i].hit ? 3 : 2;
                if (cyc == q[i].k + lat) begin
                    e_rv  = 1'b1;
                    e_err = !q[i].hit;
                    e_rd  = (q[i].hit && !q[i].write) ? q[i].rdata : 32'h0;
                end
            end
            while (q.size() > 0 && cyc >= q[0].k + (q[0].hit ? 3 : 2)) void'(q.pop_front());
        end
        e_rdy = !r && (cyc >= free_at);

        check("cmd_ready", {31'b0, cmd_ready}, {31'b0, e_rdy});
        check("Pselx", {28'b0, Pselx}, {28'b0, e_sel});
        check("Penable", {31'b0, Penable}, {31'b0, e_en});
        check("Paddr", Paddr, m_paddr);
        check("Pwdata", Pwdata, m_pwdata);
        check("Pwrite", {31'b0, Pwrite}, {31'b0, m_pwrite});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
        if (e_rv) begin
            check("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
            check("rsp_rdata", rsp_rdata, e_rd);
        end

        if (e_rdy && v) begin
            a_hit   = ((a >> (SZ + 2)) == (BASE >> (SZ + 2)));
            t.k     = cyc;
            t.write = w;
            t.hit   = a_hit;
            t.addr  = a;
            t.wdata = d;
            t.rdata = 32'h0;
            q.push_back(t);
            free_at = cyc + 2;
        end
        rst_prev = r;
        cyc++;
    endtask

    task automatic idle(input int n, input logic [31:0] prd);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, prd);
    endtask

    initial begin
        logic [31:0] ra;
        bit          rr;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'h1, 32'h0);
        idle(2, 32'h0);

        // Write into slave 1.
        step(1'b0, 1'b1, 1'b1, 32'h8000_0404, 32'hDEAD_BEEF, 32'h0);
        idle(4, 32'h0);

        // Read from slave 3 with fixed read data.
        step(1'b0, 1'b1, 1'b0, 32'h8000_0C10, 32'h0, 32'h0);
        idle(4, 32'h1234_5678);

        // Valid held across SETUP: second command waits for ACCESS, then runs back to back.
        step(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'hA5A5_0001);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0800, 32'h0BAD_F00D, 32'hA5A5_0002);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0800, 32'h0BAD_F00D, 32'hA5A5_0003);
        idle(5, 32'hA5A5_0004);

        // Address outside the window, then a hit right behind it.
        step(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h8000_0400, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h8000_0400, 32'h0, 32'h7777_0000);
        idle(5, 32'h7777_1111);

        // Reset asserted in ACCESS drops the transfer; the next command runs normally.
        step(1'b0, 1'b1, 1'b0, 32'h8000_0C00, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5555_5555);
        idle(2, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0004, 32'hCAFE_0001, 32'h0);
        idle(4, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 59) == 0);
            ra = ($urandom_range(0, 4) != 0) ? (BASE | ($urandom & 32'h0000_0FFF)) : $urandom;
            step(rr, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, ra, $urandom, $urandom);
        end
        idle(6, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
